alu_operand_sequencer: RTL and testbench

- Parametrised successor to the board-level ALU operand loader.
- Latches operand A, operand B and the opcode from SWITCH using three push buttons.
- Each button is synchronised, debounced and edge-detected, so one press loads exactly once.
- Contains the ALU and drives a registered result plus status flags to LEDs. Sits directly under the board top, between the pins and the display.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_operand_sequencer_if.sv | 24 ++
 rtl/button_conditioner.sv | 44 ++++
 rtl/alu_operand_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_operand_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operand sequencer: opcode encodings and button lanes.
package alu_seq_pkg;

    // MIPS funct-field encodings
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_OP  = 2;
    localparam int NUM_BTN = 3;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Board-side signal bundle: switches and buttons in, result LEDs and status out.
interface alu_operand_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] SWITCH;
    logic [2:0]       BOT;
    logic [WIDTH-1:0] LED;
    logic             ZERO;
    logic             CARRY;
    logic             OVF;
    logic             OP_ERR;
    logic [2:0]       LOADED;
    logic             VALID;

    modport master (
        output SWITCH, BOT,
        input  LED, ZERO, CARRY, OVF, OP_ERR, LOADED, VALID
    );

    modport slave (
        input  SWITCH, BOT,
        output LED, ZERO, CARRY, OVF, OP_ERR, LOADED, VALID
    );
endinterface

// File: rtl/button_conditioner.sv
// One button lane: 2-FF synchroniser, stability counter, rising-edge pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RAW,
    output logic PULSE
);
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= RAW;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Gated by RESET so the cycle a reset lands can never look like a press.
    assign PULSE = r_deb & ~r_deb_d & ~RESET;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Loads A, B and opcode from the switches on debounced button presses and shows the ALU result.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int OP_WIDTH        = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    alu_operand_sequencer_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic [NUM_BTN-1:0]  w_pulse;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [OP_WIDTH-1:0] r_op;
    logic [NUM_BTN-1:0]  r_loaded;

    logic [WIDTH-1:0]    r_led;
    logic                r_zero;
    logic                r_carry;
    logic                r_ovf;
    logic                r_err;
    logic                r_valid;

    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_res;
    logic                w_carry;
    logic                w_ovf;
    logic                w_err;
    logic [SH_W-1:0]     w_shamt;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .CLK  (CLK),
                .RESET(RESET),
                .RAW  (bus.BOT[gi]),
                .PULSE(w_pulse[gi])
            );
        end
    endgenerate

    // Fixed priority; a lower-priority pulse in the same cycle is simply lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_loaded <= '0;
        end else if (w_pulse[BTN_A]) begin
            r_a             <= bus.SWITCH;
            r_loaded[BTN_A] <= 1'b1;
        end else if (w_pulse[BTN_B]) begin
            r_b             <= bus.SWITCH;
            r_loaded[BTN_B] <= 1'b1;
        end else if (w_pulse[BTN_OP]) begin
            r_op             <= bus.SWITCH[OP_WIDTH-1:0];
            r_loaded[BTN_OP] <= 1'b1;
        end
    end

    assign w_shamt = r_b[SH_W-1:0];

    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (r_op)
            OP_WIDTH'(OP_ADD): begin
                w_sum   = {1'b0, r_a} + {1'b0, r_b};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_WIDTH'(OP_SUB): begin
                // Bit WIDTH of the widened difference is the borrow.
                w_sum   = {1'b0, r_a} - {1'b0, r_b};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_WIDTH'(OP_AND): w_res = r_a & r_b;
            OP_WIDTH'(OP_OR):  w_res = r_a | r_b;
            OP_WIDTH'(OP_XOR): w_res = r_a ^ r_b;
            OP_WIDTH'(OP_NOR): w_res = ~(r_a | r_b);
            OP_WIDTH'(OP_SRL): w_res = r_a >> w_shamt;
            OP_WIDTH'(OP_SRA): w_res = $unsigned($signed(r_a) >>> w_shamt);
            default:           w_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_led   <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_led   <= w_res;
            r_zero  <= (w_res == '0);
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_err   <= w_err;
            r_valid <= &r_loaded;
        end
    end

    assign bus.LED    = r_led;
    assign bus.ZERO   = r_zero;
    assign bus.CARRY  = r_carry;
    assign bus.OVF    = r_ovf;
    assign bus.OP_ERR = r_err;
    assign bus.LOADED = r_loaded;
    assign bus.VALID  = r_valid;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: vector table of operand/opcode loads plus debounce, priority and reset sequences.
module tb_alu_operand_sequencer;

    logic clk;
    logic rst;

    alu_operand_sequencer_if #(.WIDTH(8)) bus ();

    alu_operand_sequencer #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .OP_WIDTH       (6)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] led;
        logic       z;
        logic       c;
        logic       v;
        logic       e;
    } vec_t;

    vec_t vecs [12];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int pcnt      [3];
    int pulse_cyc [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle and sample the load pulses away from the active edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (dut.w_pulse[i]) begin
                pcnt[i]++;
                pulse_cyc[i] = cyc;
            end
        end
    endtask

    task automatic press(input int idx, input logic [7:0] sw);
        bus.SWITCH   = sw;
        bus.BOT[idx] = 1'b1;
        repeat (10) step();
        bus.BOT[idx] = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        int p0, p1, p2, c0;
        logic [7:0] cur_b;

        #100000;
        $display("FAIL timeout: bench did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, p1, p2, c0;
        logic [7:0] cur_b;

        vecs[0]  = '{8'h7F, 8'h01, 6'b100000, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{8'h00, 8'h01, 6'b100010, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h80, 8'h03, 6'b000011, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'hF0, 8'h3C, 6'b100100, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'hF0, 8'h0F, 6'b100101, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'hAA, 8'hAA, 6'b100110, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h0F, 8'hF0, 6'b100111, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h80, 8'h03, 6'b000010, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 8'h01, 6'b100000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'h80, 8'h01, 6'b100010, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h12, 8'h34, 6'b111111, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{8'hF0, 8'h0B, 6'b000010, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 3; i++) begin
            pcnt[i]      = 0;
            pulse_cyc[i] = -1;
        end
        bus.SWITCH = 8'h00;
        bus.BOT    = 3'b000;
        rst        = 1'b1;

        // Reset state
        repeat (3) step();
        chk("reset_led",    32'(bus.LED),    32'h0);
        chk("reset_flags",  32'({bus.ZERO, bus.CARRY, bus.OVF, bus.OP_ERR}), 32'h0);
        chk("reset_loaded", 32'(bus.LOADED), 32'h0);
        chk("reset_valid",  32'(bus.VALID),  32'h0);
        rst = 1'b0;
        repeat (3) step();
        chk("op0_err_zero", 32'({bus.OP_ERR, bus.ZERO}), 32'h3);

        // Single press: one pulse at t+6, A loaded
        p0 = pcnt[0];
        c0 = cyc;
        bus.SWITCH = 8'h05;
        bus.BOT[0] = 1'b1;
        repeat (10) step();
        chk("press_pulse_count", 32'(pcnt[0] - p0), 32'd1);
        chk("press_pulse_time",  32'(pulse_cyc[0] - c0), 32'd6);
        bus.BOT[0] = 1'b0;
        repeat (8) step();
        chk("press_no_release_pulse", 32'(pcnt[0] - p0), 32'd1);
        chk("press_a",      32'(dut.r_a),    32'h05);
        chk("press_loaded", 32'(bus.LOADED), 32'h1);
        chk("press_valid",  32'(bus.VALID),  32'h0);
        $display("press A: A=0x%0h LOADED=%b VALID=%b", dut.r_a, bus.LOADED, bus.VALID);

        // Short pulse on B and bouncing OP button must not load
        p1 = pcnt[1];
        p2 = pcnt[2];
        bus.SWITCH = 8'hC3;
        bus.BOT[1] = 1'b1;
        repeat (3) step();
        bus.BOT[1] = 1'b0;
        bus.BOT[2] = 1'b1; step();
        bus.BOT[2] = 1'b0; step();
        bus.BOT[2] = 1'b1; step();
        bus.BOT[2] = 1'b0;
        repeat (10) step();
        chk("glitch_b_pulses",  32'(pcnt[1] - p1), 32'd0);
        chk("bounce_op_pulses", 32'(pcnt[2] - p2), 32'd0);
        chk("glitch_loaded",    32'(bus.LOADED),   32'h1);
        $display("glitch: LOADED=%b", bus.LOADED);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            press(0, vecs[i].a);
            press(1, vecs[i].b);
            press(2, {2'b00, vecs[i].op});
            $display("vec %0d: A=0x%0h B=0x%0h OP=%b -> LED=0x%0h Z=%b C=%b V=%b E=%b VALID=%b",
                     i, vecs[i].a, vecs[i].b, vecs[i].op, bus.LED, bus.ZERO, bus.CARRY,
                     bus.OVF, bus.OP_ERR, bus.VALID);
            chk($sformatf("vec%0d_led", i),    32'(bus.LED),    32'(vecs[i].led));
            chk($sformatf("vec%0d_zero", i),   32'(bus.ZERO),   32'(vecs[i].z));
            chk($sformatf("vec%0d_carry", i),  32'(bus.CARRY),  32'(vecs[i].c));
            chk($sformatf("vec%0d_ovf", i),    32'(bus.OVF),    32'(vecs[i].v));
            chk($sformatf("vec%0d_op_err", i), 32'(bus.OP_ERR), 32'(vecs[i].e));
            chk($sformatf("vec%0d_valid", i),  32'(bus.VALID),  32'h1);
        end
        cur_b = vecs[11].b;

        // Operand change shows one cycle after the register update
        bus.SWITCH = 8'h20;
        bus.BOT[0] = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 7) step();
        chk("a_update_reg", 32'(dut.r_a), 32'h20);
        chk("a_update_led_old", 32'(bus.LED), 32'h1E);
        step();
        chk("a_update_led_new", 32'(bus.LED), 32'h04);
        bus.BOT[0] = 1'b0;
        repeat (8) step();
        $display("operand change: A=0x%0h LED=0x%0h", dut.r_a, bus.LED);

        // Simultaneous A and B presses: only A loads
        p0 = pcnt[0];
        p1 = pcnt[1];
        bus.SWITCH = 8'h33;
        bus.BOT[0] = 1'b1;
        bus.BOT[1] = 1'b1;
        repeat (10) step();
        bus.BOT[0] = 1'b0;
        bus.BOT[1] = 1'b0;
        repeat (8) step();
        chk("simul_pulses_a", 32'(pcnt[0] - p0), 32'd1);
        chk("simul_pulses_b", 32'(pcnt[1] - p1), 32'd1);
        chk("simul_a", 32'(dut.r_a), 32'h33);
        chk("simul_b", 32'(dut.r_b), 32'(cur_b));
        $display("simultaneous: A=0x%0h B=0x%0h", dut.r_a, dut.r_b);

        press(2, 8'h3F);
        chk("undef_led",  32'(bus.LED),    32'h00);
        chk("undef_err",  32'(bus.OP_ERR), 32'h1);
        chk("undef_zero", 32'(bus.ZERO),   32'h1);
        press(2, 8'h20);
        chk("add_before_reset", 32'(bus.LED), 32'h3E);
        $display("undefined then ADD: LED=0x%0h", bus.LED);

        // Reset for one cycle in the middle of a debounce with A held
        p0 = pcnt[0];
        c0 = cyc;
        bus.SWITCH = 8'h5A;
        bus.BOT[0] = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_led",    32'(bus.LED), 32'h0);
        chk("midrst_flags",  32'({bus.ZERO, bus.CARRY, bus.OVF, bus.OP_ERR}), 32'h0);
        chk("midrst_loaded", 32'(bus.LOADED), 32'h0);
        chk("midrst_valid",  32'(bus.VALID),  32'h0);
        chk("midrst_a",      32'(dut.r_a),    32'h0);
        chk("midrst_no_pulse", 32'(pcnt[0] - p0), 32'd0);
        rst = 1'b0;
        repeat (10) step();
        chk("midrst_pulse_count", 32'(pcnt[0] - p0), 32'd1);
        chk("midrst_pulse_time",  32'(pulse_cyc[0] - c0), 32'd9);
        bus.BOT[0] = 1'b0;
        repeat (8) step();
        chk("midrst_a_loaded", 32'(dut.r_a),    32'h5A);
        chk("midrst_loaded_a", 32'(bus.LOADED), 32'h1);
        chk("midrst_valid_0",  32'(bus.VALID),  32'h0);
        $display("reset mid-debounce: A=0x%0h LOADED=%b", dut.r_a, bus.LOADED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
